// File: rtl/multiplexor_n_a_1_secuencial_if.sv
// Channel bus of the sequential N-to-1 multiplexor: flattened channel data,
// selection controls and the registered selection result.
interface multiplexor_n_a_1_secuencial_if #(
    parameter int ANCHO     = 3,
    parameter int CANALES   = 4,
    parameter int ANCHO_SEL = 3
);
    logic [CANALES*ANCHO-1:0] Entradas;
    logic [ANCHO_SEL-1:0]     Selector;
    logic                     Modo;
    logic                     Habilitar;
    logic [ANCHO-1:0]         Salida;
    logic [ANCHO_SEL-1:0]     Canal;
    logic                     Valido;
    logic                     Error;

    modport master (
        output Entradas,
        output Selector,
        output Modo,
        output Habilitar,
        input  Salida,
        input  Canal,
        input  Valido,
        input  Error
    );

    modport slave (
        input  Entradas,
        input  Selector,
        input  Modo,
        input  Habilitar,
        output Salida,
        output Canal,
        output Valido,
        output Error
    );
endinterface

// File: rtl/multiplexor_n_a_1_secuencial.sv
// Registered N-to-1 channel multiplexor with a manual selector mode and an
// automatic scan mode that dwells PERMANENCIA cycles on each channel.
module multiplexor_n_a_1_secuencial #(
    parameter int ANCHO       = 3,
    parameter int CANALES     = 4,
    parameter int ANCHO_SEL   = 3,
    parameter int PERMANENCIA = 4
) (
    input logic                          Reloj,
    input logic                          Reset,
    multiplexor_n_a_1_secuencial_if.slave bus
);

    localparam int CNT_W = (PERMANENCIA > 1) ? $clog2(PERMANENCIA) : 1;
    localparam logic [CNT_W-1:0]     ULTIMA_CUENTA = CNT_W'(PERMANENCIA - 1);
    localparam logic [ANCHO_SEL-1:0] ULTIMO_CANAL  = ANCHO_SEL'(CANALES - 1);

    typedef enum logic [0:0] {
        MANUAL  = 1'b0,
        BARRIDO = 1'b1
    } estado_t;

    // Out-of-range indices yield zero so no X can reach the data register.
    function automatic logic [ANCHO-1:0] dato_canal(
        input logic [CANALES*ANCHO-1:0] ent,
        input logic [ANCHO_SEL-1:0]     idx
    );
        logic [ANCHO-1:0] r;
        r = {ANCHO{1'b0}};
        for (int unsigned k = 0; k < CANALES; k++) begin
            r = (32'(idx) == k) ? ent[k*ANCHO +: ANCHO] : r;
        end
        return r;
    endfunction

    estado_t              estado_r, estado_s;
    logic [ANCHO-1:0]     salida_r, salida_s;
    logic [ANCHO_SEL-1:0] canal_r, canal_s;
    logic                 valido_r, valido_s;
    logic                 error_r, error_s;
    logic [CNT_W-1:0]     cuenta_r, cuenta_s;
    logic [ANCHO_SEL-1:0] sig_canal_s;
    logic                 sel_valido_s;

    // Scan successor and manual range check.
    always_comb begin
        sig_canal_s  = (canal_r == ULTIMO_CANAL) ? {ANCHO_SEL{1'b0}}
                                                 : canal_r + ANCHO_SEL'(1);
        sel_valido_s = (32'(bus.Selector) < 32'(CANALES));
    end

    // Next-state and next-output logic; everything holds unless enabled.
    always_comb begin
        estado_s = estado_r;
        salida_s = salida_r;
        canal_s  = canal_r;
        valido_s = 1'b0;
        error_s  = error_r;
        cuenta_s = cuenta_r;

        if (bus.Habilitar) begin
            if (bus.Modo) begin
                estado_s = BARRIDO;
                case (estado_r)
                    MANUAL: begin
                        canal_s  = {ANCHO_SEL{1'b0}};
                        salida_s = dato_canal(bus.Entradas, {ANCHO_SEL{1'b0}});
                        cuenta_s = {CNT_W{1'b0}};
                        error_s  = 1'b0;
                        valido_s = 1'b1;
                    end
                    BARRIDO: begin
                        if (cuenta_r == ULTIMA_CUENTA) begin
                            cuenta_s = {CNT_W{1'b0}};
                            canal_s  = sig_canal_s;
                            salida_s = dato_canal(bus.Entradas, sig_canal_s);
                            valido_s = 1'b1;
                        end else begin
                            cuenta_s = cuenta_r + CNT_W'(1);
                            salida_s = dato_canal(bus.Entradas, canal_r);
                            valido_s = 1'b0;
                        end
                    end
                    default: begin
                        estado_s = MANUAL;
                        cuenta_s = {CNT_W{1'b0}};
                    end
                endcase
            end else begin
                // Leaving the scan discards any partial dwell.
                estado_s = MANUAL;
                cuenta_s = {CNT_W{1'b0}};
                if (sel_valido_s) begin
                    canal_s  = bus.Selector;
                    salida_s = dato_canal(bus.Entradas, bus.Selector);
                    error_s  = 1'b0;
                    valido_s = 1'b1;
                end else begin
                    error_s  = 1'b1;
                    valido_s = 1'b0;
                end
            end
        end else begin
            valido_s = 1'b0;
        end
    end

    // State, dwell counter and output registers.
    always_ff @(posedge Reloj or posedge Reset) begin
        if (Reset) begin
            estado_r <= MANUAL;
            salida_r <= {ANCHO{1'b0}};
            canal_r  <= {ANCHO_SEL{1'b0}};
            valido_r <= 1'b0;
            error_r  <= 1'b0;
            cuenta_r <= {CNT_W{1'b0}};
        end else begin
            estado_r <= estado_s;
            salida_r <= salida_s;
            canal_r  <= canal_s;
            valido_r <= valido_s;
            error_r  <= error_s;
            cuenta_r <= cuenta_s;
        end
    end

    assign bus.Salida = salida_r;
    assign bus.Canal  = canal_r;
    assign bus.Valido = valido_r;
    assign bus.Error  = error_r;

endmodule

// File: tb/tb_multiplexor_n_a_1_secuencial.sv
// Randomised and directed bench for the sequential multiplexor, checked each
// cycle against a scan-position model plus hand-computed expectations.
module tb_multiplexor_n_a_1_secuencial;

    localparam int ANCHO       = 3;
    localparam int CANALES     = 4;
    localparam int ANCHO_SEL   = 3;
    localparam int PERMANENCIA = 4;

    logic Reloj;
    logic Reset;
    int   n_checks;
    int   n_pass;

    multiplexor_n_a_1_secuencial_if #(
        .ANCHO(ANCHO), .CANALES(CANALES), .ANCHO_SEL(ANCHO_SEL)
    ) bus ();

    multiplexor_n_a_1_secuencial #(
        .ANCHO(ANCHO), .CANALES(CANALES), .ANCHO_SEL(ANCHO_SEL),
        .PERMANENCIA(PERMANENCIA)
    ) dut (
        .Reloj(Reloj),
        .Reset(Reset),
        .bus(bus)
    );

    initial Reloj = 1'b0;
    always #5 Reloj = ~Reloj;

    // Scan mode is modelled as a position counted from scan entry:
    // channel = (pos / PERMANENCIA) mod CANALES, new channel when pos mod PERMANENCIA == 0.
    typedef struct {
        logic [ANCHO-1:0]     salida;
        logic [ANCHO_SEL-1:0] canal;
        logic                 valido;
        logic                 error;
        bit                   barrido;
        int                   pos;
    } modelo_t;

    modelo_t m;

    function automatic modelo_t modelo_reset();
        modelo_t r;
        r.salida = '0; r.canal = '0; r.valido = 1'b0; r.error = 1'b0;
        r.barrido = 1'b0; r.pos = 0;
        return r;
    endfunction

    function automatic modelo_t paso(input modelo_t s, input logic hab, input logic modo,
                                     input logic [ANCHO_SEL-1:0] sel,
                                     input logic [CANALES*ANCHO-1:0] ent);
        modelo_t n;
        int ch;
        n = s;
        n.valido = 1'b0;
        if (hab) begin
            if (modo) begin
                n.pos     = s.barrido ? s.pos + 1 : 0;
                n.error   = s.barrido ? s.error : 1'b0;
                n.barrido = 1'b1;
                ch        = (n.pos / PERMANENCIA) % CANALES;
                n.canal   = ANCHO_SEL'(ch);
                n.salida  = ent[ch*ANCHO +: ANCHO];
                n.valido  = ((n.pos % PERMANENCIA) == 0);
            end else begin
                n.barrido = 1'b0;
                n.pos     = 0;
                if (int'(sel) < CANALES) begin
                    n.canal  = sel;
                    n.salida = ent[int'(sel)*ANCHO +: ANCHO];
                    n.error  = 1'b0;
                    n.valido = 1'b1;
                end else begin
                    n.error = 1'b1;
                end
            end
        end
        return n;
    endfunction

    always @(posedge Reloj or posedge Reset) begin
        if (Reset) m <= modelo_reset();
        else       m <= paso(m, bus.Habilitar, bus.Modo, bus.Selector, bus.Entradas);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge Reloj) begin
        check("modelo_salida", 32'(bus.Salida), 32'(m.salida));
        check("modelo_canal",  32'(bus.Canal),  32'(m.canal));
        check("modelo_valido", 32'(bus.Valido), 32'(m.valido));
        check("modelo_error",  32'(bus.Error),  32'(m.error));
    end

    task automatic tick();
        @(posedge Reloj);
        #1;
    endtask

    task automatic check_out(input string name, input logic [ANCHO-1:0] sal,
                             input logic [ANCHO_SEL-1:0] can, input logic val,
                             input logic err);
        check({name, "_salida"}, 32'(bus.Salida), 32'(sal));
        check({name, "_canal"},  32'(bus.Canal),  32'(can));
        check({name, "_valido"}, 32'(bus.Valido), 32'(val));
        check({name, "_error"},  32'(bus.Error),  32'(err));
    endtask

    logic [CANALES*ANCHO-1:0] ch_fijos;
    logic [ANCHO-1:0]         dato_fijo [CANALES];

    initial begin
        n_checks = 0;
        n_pass   = 0;
        dato_fijo = '{3'b001, 3'b100, 3'b101, 3'b110};
        ch_fijos  = {3'b110, 3'b101, 3'b100, 3'b001};
        Reset = 1'b1;
        bus.Entradas  = ch_fijos;
        bus.Selector  = 3'b000;
        bus.Modo      = 1'b0;
        bus.Habilitar = 1'b0;

        // Reset state before the first enabled edge
        repeat (2) tick();
        Reset = 1'b0;
        check_out("reset", 3'b000, 3'b000, 1'b0, 1'b0);

        // Manual stepping through all channels
        bus.Habilitar = 1'b1;
        for (int i = 0; i < CANALES; i++) begin
            bus.Selector = ANCHO_SEL'(i);
            tick();
            check_out("manual", dato_fijo[i], ANCHO_SEL'(i), 1'b1, 1'b0);
        end

        // Out-of-range selectors hold data and flag Error
        bus.Selector = 3'b011; tick();
        bus.Selector = 3'b100; tick();
        check_out("fuera_rango_4", 3'b110, 3'b011, 1'b0, 1'b1);
        bus.Selector = 3'b101; tick();
        check_out("fuera_rango_5", 3'b110, 3'b011, 1'b0, 1'b1);
        bus.Selector = 3'b001; tick();
        check_out("recupera", 3'b100, 3'b001, 1'b1, 1'b0);

        // Seventeen scan cycles
        bus.Modo = 1'b1;
        for (int i = 0; i < 17; i++) begin
            tick();
            check_out("barrido", dato_fijo[(i / 4) % 4], ANCHO_SEL'((i / 4) % 4),
                      ((i % 4) == 0), 1'b0);
        end

        // Freeze at channel 1, dwell count 2
        bus.Modo = 1'b0; tick();
        bus.Modo = 1'b1;
        repeat (7) tick();
        check_out("pre_congelar", 3'b100, 3'b001, 1'b0, 1'b0);
        bus.Habilitar = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_out("congelado", 3'b100, 3'b001, 1'b0, 1'b0);
        end
        bus.Habilitar = 1'b1;
        tick();
        check_out("reanuda_1", 3'b100, 3'b001, 1'b0, 1'b0);
        tick();
        check_out("reanuda_2", 3'b101, 3'b010, 1'b1, 1'b0);

        // Asynchronous reset mid-dwell on channel 2
        tick();
        #2 Reset = 1'b1;
        #1 check_out("reset_async", 3'b000, 3'b000, 1'b0, 1'b0);
        tick();
        #2 Reset = 1'b0;
        tick();
        check_out("post_reset", 3'b001, 3'b000, 1'b1, 1'b0);

        // Randomised traffic, occasional async reset pulses
        for (int i = 0; i < 400; i++) begin
            bus.Entradas  = CANALES*ANCHO'($urandom);
            bus.Selector  = ANCHO_SEL'($urandom_range(0, 7));
            bus.Habilitar = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) bus.Modo = ~bus.Modo;
            if ($urandom_range(0, 49) == 0) begin
                Reset = 1'b1;
                #2 Reset = 1'b0;
            end
            tick();
        end

        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multiplexor_n_a_1_secuencial.md
Name: multiplexor_n_a_1_secuencial

Overview:
Parametrised, registered successor of the 4-to-1 multiplexor. It selects one of CANALES input channels of ANCHO bits each. Manual mode follows a selector and flags out-of-range codes. Barrido mode scans the channels automatically, holding each for a fixed number of cycles. Its intended use is as the channel-sequencing front end for display and monitoring datapaths.

Parameters:
ANCHO, 3, bit width of each channel and of Salida.
CANALES, 4, number of input channels; must be ≥ 2.
ANCHO_SEL, 3, width of Selector and Canal; must satisfy 2**ANCHO_SEL ≥ CANALES.
PERMANENCIA, 4, dwell time in cycles per channel in barrido mode; must be ≥ 1.

Ports:
Reloj  input  1  system clock; all state updates on its rising edge.
Reset  input  1  asynchronous, active-high reset.
Entradas  input  CANALES*ANCHO  flattened channels; channel k is Entradas[k*ANCHO +: ANCHO].
Selector  input  ANCHO_SEL  channel request in manual mode; ignored in barrido mode.
Modo  input  1  0 = manual, 1 = barrido (auto-scan).
Habilitar  input  1  clock enable; 0 freezes all state.
Salida  output  ANCHO  registered selected data.
Canal  output  ANCHO_SEL  index of the channel currently driving Salida.
Valido  output  1  high for the cycle after Salida/Canal is loaded with a valid channel.
Error  output  1  high while the last sampled manual Selector was out of range.

Behaviour:
- Reset (asynchronous, immediate on Reset=1, any state): Salida=0, Canal=0, Valido=0, Error=0, dwell counter=0, state MANUAL.
- States are MANUAL and BARRIDO. Each enabled edge samples Modo: Modo=1 → BARRIDO, Modo=0 → MANUAL.
- Habilitar=0:
  - Salida, Canal, Error, dwell counter and state hold.
  - Valido=0.
  - Modo is not sampled.
- MANUAL, Habilitar=1, Selector < CANALES:
  - Canal ← Selector; Salida ← channel[Selector].
  - Error ← 0; Valido ← 1.
  - Latency is exactly 1 cycle from Selector to Salida.
- MANUAL, Habilitar=1, Selector ≥ CANALES (e.g. 3'b100 with CANALES=4):
  - Salida and Canal hold.
  - Error ← 1; Valido ← 0.
  - No X propagates to Salida.
- Entry into BARRIDO (previous state MANUAL, Modo=1, enabled):
  - Canal ← 0; Salida ← channel[0]; counter ← 0.
  - Error ← 0; Valido ← 1.
- BARRIDO, enabled, counter < PERMANENCIA−1:
  - counter++; Canal holds.
  - Salida ← channel[Canal], so Salida tracks live data of the current channel.
  - Valido ← 0.
- BARRIDO, enabled, counter = PERMANENCIA−1:
  - counter ← 0; Canal ← next.
  - Salida ← channel[next]; Valido ← 1.
  - next = Canal+1, wrapping CANALES−1 → 0.
- PERMANENCIA=1: Canal advances every enabled cycle and Valido stays high.
- Salida and Canal always correspond to each other on the same edge; next-channel selection is combinational and both are registered together.
- BARRIDO → MANUAL: the partial dwell count is discarded (counter ← 0). Manual rules apply to that same edge using the current Selector.
- Error is cleared on any valid manual load and on BARRIDO entry. It is never set in BARRIDO.
- Reset asserted mid-dwell or mid-scan: all state returns to reset values immediately. After release, operation resumes in MANUAL on the first enabled edge.

Test Plan:
All scenarios use ANCHO=3, CANALES=4, PERMANENCIA=4, and channels 0..3 = 001, 100, 101, 110.

1. Reset=1 for 2 cycles, then release → Salida=000, Canal=000, Valido=0, Error=0 before the first enabled edge.
2. Manual mode, Habilitar=1, Selector stepped 000, 001, 010, 011 every 10 ns → one cycle later, Salida = 001, 100, 101, 110 and Canal matches; Valido=1 throughout.
3. Manual mode, Selector=011 then 100, then 101, then 001:
   - Salida holds 110 and Canal holds 011 while Selector is 100 and 101.
   - Error=1 and Valido=0 during those cycles.
   - When Selector=001: Salida=100, Error=0, Valido=1.
4. Modo=1 for 17 enabled cycles:
   - Canal sequence is 0×4, 1×4, 2×4, 3×4, then 0.
   - Valido pulses on cycles 0, 4, 8, 12 and 16 only.
   - Salida equals the channel indexed by Canal in every cycle.
5. Barrido mode, Habilitar=0 for 5 cycles at counter=2 on channel 1 → Salida, Canal and counter frozen and Valido=0. After re-enable, Canal stays 1 for exactly 2 more cycles, then moves to 2.
6. Barrido mode on channel 2 mid-dwell, then Reset pulsed asynchronously between clock edges → outputs go to 0 immediately, without waiting for a clock edge. After release with Modo=1, the first enabled edge enters BARRIDO: Canal=0, Salida=001, Valido=1.
